// File: rtl/l128d128_sram_ctrl.sv
// Access controller for a 128x128 bit-masked SRAM macro with active-low controls.
// Zero-fills the array after reset or clear, then round-robins two requesters
// at one access per cycle and returns read data with one-cycle latency.
module l128d128_sram_ctrl #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  output logic              init_done_o,
  input  logic              p0_valid_i,
  output logic              p0_ready_o,
  input  logic              p0_wen_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  input  logic [DATA_W-1:0] p0_wmask_i,
  output logic              p0_rvalid_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  input  logic              p1_valid_i,
  output logic              p1_ready_o,
  input  logic              p1_wen_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  input  logic [DATA_W-1:0] p1_wmask_i,
  output logic              p1_rvalid_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  output logic              sram_cen_o,
  output logic              sram_wen_o,
  output logic [DATA_W-1:0] sram_bwen_o,
  output logic [ADDR_W-1:0] sram_a_o,
  output logic [ADDR_W-1:0] sram_a_n_o,
  output logic [DATA_W-1:0] sram_d_o,
  input  logic [DATA_W-1:0] sram_q_i
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rr_q, rr_d;
  logic                init_done_q, init_done_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   hold0_q, hold0_d, hold1_q, hold1_d;

  logic                gnt0, gnt1, req_ok;
  logic                sel_wen;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata, sel_wmask;

  // Round-robin grant; rr_q=0 favours port 0 when both request.
  always_comb begin
    req_ok    = (state_q == ST_RUN) && !rst_i && !clr_i;
    gnt0      = req_ok && p0_valid_i && (!p1_valid_i || !rr_q);
    gnt1      = req_ok && p1_valid_i && (!p0_valid_i || rr_q);
    sel_wen   = gnt1 ? p1_wen_i   : p0_wen_i;
    sel_addr  = gnt1 ? p1_addr_i  : p0_addr_i;
    sel_wdata = gnt1 ? p1_wdata_i : p0_wdata_i;
    sel_wmask = gnt1 ? p1_wmask_i : p0_wmask_i;
  end

  // Macro control: zero-fill writes in INIT, granted access in RUN, idle otherwise.
  always_comb begin
    sram_cen_o  = 1'b1;
    sram_wen_o  = 1'b1;
    sram_bwen_o = '1;
    sram_a_o    = '0;
    sram_d_o    = '0;
    if (!rst_i) begin
      if (state_q == ST_INIT) begin
        sram_cen_o  = 1'b0;
        sram_wen_o  = 1'b0;
        sram_bwen_o = '0;
        sram_a_o    = cnt_q;
      end else if (gnt0 || gnt1) begin
        sram_cen_o = 1'b0;
        sram_a_o   = sel_addr;
        if (sel_wen) begin
          sram_wen_o  = 1'b0;
          sram_bwen_o = ~sel_wmask;
          sram_d_o    = sel_wdata;
        end
      end
    end
  end

  // Next-state: sweep counter, state, RR pointer, read response tracking.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    rvalid0_d = gnt0 && !p0_wen_i;
    rvalid1_d = gnt1 && !p1_wen_i;
    hold0_d   = rvalid0_q ? sram_q_i : hold0_q;
    hold1_d   = rvalid1_q ? sram_q_i : hold1_q;
    if (state_q == ST_INIT) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (cnt_q == LAST_ADDR) begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + ADDR_W'(1);
      end
    end else if (clr_i) begin
      cnt_d   = '0;
      state_d = ST_INIT;
    end
    if (gnt0) begin
      rr_d = 1'b1;
    end else if (gnt1) begin
      rr_d = 1'b0;
    end
    init_done_d = (state_d == ST_RUN);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      init_done_q <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      hold0_q     <= '0;
      hold1_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      init_done_q <= init_done_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
    end
  end

  assign init_done_o = init_done_q;
  assign p0_ready_o  = gnt0;
  assign p1_ready_o  = gnt1;
  assign p0_rvalid_o = rvalid0_q;
  assign p1_rvalid_o = rvalid1_q;
  assign p0_rdata_o  = rvalid0_q ? sram_q_i : hold0_q;
  assign p1_rdata_o  = rvalid1_q ? sram_q_i : hold1_q;
  assign sram_a_n_o  = sram_a_o;

endmodule

// File: doc/l128d128_sram_ctrl.md
# l128d128_sram_ctrl

Access controller for the 128x128 bit-write-masked SRAM macro (active-low CEN/WEN/BWEN, one-cycle registered read). It zero-initialises the array after reset or on a clear request, then arbitrates two requesters (port 0 and port 1, e.g. refill writer and lookup reader) round-robin at one access per cycle. It also translates active-high requests into the macro's active-low controls and returns read data with one-cycle latency, holding it stable afterwards.

## Interface
- DATA_W, 128, data/mask width
- ADDR_W, 7, address width
- DEPTH, 128, number of words; init sweep length
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- clr  in  1  pulse: restart zero-init sweep
- init_done  out  1  high when array initialised and ports serviceable
- pN_valid  in  1  request valid (N = 0, 1)
- pN_ready  out  1  request accepted this cycle
- pN_wen  in  1  1 = write, 0 = read
- pN_addr  in  ADDR_W  word address
- pN_wdata  in  DATA_W  write data
- pN_wmask  in  DATA_W  bit write enable, active-high
- pN_rvalid  out  1  read response valid (one-cycle pulse)
- pN_rdata  out  DATA_W  read data
- sram_cen  out  1  macro chip enable, active-low
- sram_wen  out  1  macro write enable, active-low
- sram_bwen  out  DATA_W  macro bit write enable, active-low
- sram_a  out  ADDR_W  macro address
- sram_a_n  out  ADDR_W  macro second read address; always equals sram_a
- sram_d  out  DATA_W  macro write data
- sram_q  in  DATA_W  macro read data (registered in macro)

## Operation
- States: INIT, RUN.
- Reset (rst high, synchronous): state INIT, init counter 0, RR pointer 0 (port 0 favoured), rvalid regs 0, rdata hold regs 0, init_done 0. While rst is high, the block forces sram_cen=1 and pN_ready=0 combinationally.
- INIT: each cycle write word counter with sram_cen=0, sram_wen=0, sram_bwen=all 0, sram_d=0, sram_a=counter. The counter increments. After the write to DEPTH-1, enter RUN. pN_ready=0 throughout.
- RUN: init_done=1. Grant is combinational. If one port is valid, that port is granted. If both are valid, the port selected by the RR pointer is granted. After a grant, the pointer moves to the other port. With no grant, the pointer is unchanged. pN_ready=grant, so ready may depend on valid. A requester's valid must not depend on its ready.
- Granted write: sram_cen=0, sram_wen=0, sram_bwen=~wmask, sram_a=addr, sram_d=wdata. No response is returned.
- Granted read: sram_cen=0, sram_wen=1, sram_bwen=all 1, sram_a=addr. The next cycle, pN_rvalid=1 for the granted port and pN_rdata=sram_q. That value is latched into the port's hold register.
- pN_rdata = pN_rvalid ? sram_q : hold_N. Data is stable until that port's next read response. The macro's randomised Q is never exposed.
- No grant in RUN: sram_cen=1, sram_wen=1, sram_bwen=all 1, sram_a=0, sram_d=0.
- clr in RUN: no grant in the clr cycle, even if valid. Next state is INIT with counter 0 and init_done=0. A read granted in the previous cycle still delivers its rvalid.
- clr in INIT: counter restarts at 0.
- Read-after-write to the same address on consecutive cycles returns the new data. The macro resolves this; the controller needs no bypass.

## Timing
- Cycle 0 is the first cycle with rst low. INIT writes occur in cycles 0..DEPTH-1. init_done and first possible ready are in cycle DEPTH (128).
- Throughput: one accepted request per cycle in RUN.
- Read latency: request accepted in cycle t gives rvalid/rdata in cycle t+1. There is no backpressure on responses.
- Reset values: all pN_ready/pN_rvalid 0, pN_rdata 0, init_done 0, sram_cen 1, sram_wen 1, sram_bwen all 1.
- rst mid-operation: a pending read response is dropped (rvalid 0 next cycle) and the sweep restarts at word 0.

## Test plan
- Reset release, no requests -> exactly 128 writes with addresses 0..127 and D=0, bwen=0. init_done rises in cycle 128. A read of address 5 then returns 0.
- p0 writes addr 3 data 0xAA..AA mask all 1, then writes data 0x55..55 mask 0x0F..0F. p0 then reads addr 3 -> rvalid next cycle, rdata 0xA5..A5, and rdata holds while idle.
- p0 and p1 both valid continuously reading addrs 1 and 2 -> grants alternate p0,p1,p0,... starting with p0. Each rvalid lands only on the granted port one cycle later.
- Only p1 valid for 4 cycles -> granted every cycle. Then both valid -> p0 granted first.
- clr asserted the cycle after a p1 read grant -> p1 rvalid still delivered, ready low, init_done low. There are 128 zero writes, then a previously written address reads 0.
- rst asserted during INIT at counter 60 -> sweep restarts from address 0. init_done 128 cycles after rst release.
